// File: rtl/fpu_add_sched.sv
// Round-robin scheduler and two-stage pipeline wrapper around a combinational FP32 adder.
// Handles FSUB sign flip, dynamic rounding mode and NaN/infinity operands the adder ignores.
module fpu_add_sched #(
    parameter int FP_SIZE = 32,
    parameter int RM_W    = 3,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RM_W-1:0]    frm,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_op,
    input  logic [RM_W-1:0]    req0_rm,
    input  logic [FP_SIZE-1:0] req0_a,
    input  logic [FP_SIZE-1:0] req0_b,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_op,
    input  logic [RM_W-1:0]    req1_rm,
    input  logic [FP_SIZE-1:0] req1_a,
    input  logic [FP_SIZE-1:0] req1_b,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic [RM_W-1:0]    add_rm,
    output logic [FP_SIZE-1:0] add_a,
    output logic [FP_SIZE-1:0] add_b,
    input  logic [FP_SIZE-1:0] add_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FP_SIZE-1:0] rsp_data,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_src,
    output logic [15:0]        rsp_count
);
    localparam int EXP_W = 8;
    localparam int MAN_W = FP_SIZE - 1 - EXP_W;
    localparam logic [FP_SIZE-1:0] QNAN = FP_SIZE'(32'h7FC0_0000);

    logic               s1_valid_q, s1_src_q, s1_special_q;
    logic [RM_W-1:0]    s1_rm_q;
    logic [FP_SIZE-1:0] s1_a_q, s1_b_q, s1_spval_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               s2_valid_q, s2_src_q;
    logic [FP_SIZE-1:0] s2_data_q;
    logic [TAG_W-1:0]   s2_tag_q;
    logic [15:0]        cnt_q;
    logic               last_grant_q;

    logic               s2_free, can_accept, grant0, grant1, accept, sel;
    logic               s1_xfer, rsp_fire;
    logic               op_sel;
    logic [RM_W-1:0]    rm_sel, rm_d;
    logic [FP_SIZE-1:0] a_d, b_sel, b_d, spval_d, s2_data_d;
    logic [TAG_W-1:0]   tag_d;
    logic               spec_d;
    logic               a_exp1, b_exp1, a_man0, b_man0, a_nan, b_nan, a_inf, b_inf;

    assign s2_free    = !s2_valid_q | rsp_ready;
    assign can_accept = !s1_valid_q | s2_free;
    // On a tie the requester that did not win last time gets the slot.
    assign grant0     = req0_valid & (!req1_valid | last_grant_q);
    assign grant1     = req1_valid & (!req0_valid | !last_grant_q);
    assign req0_ready = !reset & can_accept & grant0;
    assign req1_ready = !reset & can_accept & grant1;
    assign accept     = req0_ready | req1_ready;
    assign sel        = req1_ready;
    assign s1_xfer    = s1_valid_q & s2_free;
    assign rsp_fire   = s2_valid_q & rsp_ready;

    always_comb begin
        op_sel = req0_op;
        rm_sel = req0_rm;
        a_d    = req0_a;
        b_sel  = req0_b;
        tag_d  = req0_tag;
        if (sel) begin
            op_sel = req1_op;
            rm_sel = req1_rm;
            a_d    = req1_a;
            b_sel  = req1_b;
            tag_d  = req1_tag;
        end
    end

    assign b_d  = op_sel ? {~b_sel[FP_SIZE-1], b_sel[FP_SIZE-2:0]} : b_sel;
    assign rm_d = (&rm_sel) ? frm : rm_sel;

    assign a_exp1 = &a_d[FP_SIZE-2 -: EXP_W];
    assign b_exp1 = &b_d[FP_SIZE-2 -: EXP_W];
    assign a_man0 = ~|a_d[MAN_W-1:0];
    assign b_man0 = ~|b_d[MAN_W-1:0];
    assign a_nan  = a_exp1 & !a_man0;
    assign b_nan  = b_exp1 & !b_man0;
    assign a_inf  = a_exp1 & a_man0;
    assign b_inf  = b_exp1 & b_man0;

    // Specials are resolved on the sign-flipped operand, so inf - inf becomes opposite-sign infinities.
    always_comb begin
        spec_d  = 1'b0;
        spval_d = '0;
        if (a_nan | b_nan | (a_inf & b_inf & (a_d[FP_SIZE-1] ^ b_d[FP_SIZE-1]))) begin
            spec_d  = 1'b1;
            spval_d = QNAN;
        end else if (a_inf) begin
            spec_d  = 1'b1;
            spval_d = a_d;
        end else if (b_inf) begin
            spec_d  = 1'b1;
            spval_d = b_d;
        end
    end

    assign s2_data_d = s1_special_q ? s1_spval_q : add_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_src_q     <= 1'b0;
            s1_special_q <= 1'b0;
            s1_rm_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_spval_q   <= '0;
            s1_tag_q     <= '0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            s1_valid_q   <= 1'b1;
            s1_src_q     <= sel;
            s1_special_q <= spec_d;
            s1_rm_q      <= rm_d;
            s1_a_q       <= a_d;
            s1_b_q       <= b_d;
            s1_spval_q   <= spval_d;
            s1_tag_q     <= tag_d;
            last_grant_q <= sel;
        end else if (s1_xfer) begin
            s1_valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_src_q   <= 1'b0;
        end else if (s1_xfer) begin
            s2_valid_q <= 1'b1;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s1_tag_q;
            s2_src_q   <= s1_src_q;
        end else if (rsp_fire) begin
            s2_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)         cnt_q <= '0;
        else if (rsp_fire) cnt_q <= cnt_q + 16'd1;
    end

    assign add_a     = s1_a_q;
    assign add_b     = s1_b_q;
    assign add_rm    = s1_rm_q;
    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_data_q;
    assign rsp_tag   = s2_tag_q;
    assign rsp_src   = s2_src_q;
    assign rsp_count = cnt_q;
endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Two-requester scheduler and pipeline wrapper for the single-precision combinational FP adder in the RISC-V FPU. It arbitrates FADD/FSUB requests round-robin and converts FSUB into an add by flipping the sign of B. It resolves dynamic rounding mode and handles NaN/infinity operands, which the adder datapath does not. Operands and results are registered, giving a two-stage valid/ready pipeline between the issue logic and the FP writeback path.

## Interface

**Parameters**
- FP_SIZE, 32, operand/result width.
- RM_W, 3, rounding-mode width.
- TAG_W, 5, requester tag width (destination register index).

**Ports**
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- frm  in  RM_W  dynamic rounding mode from fcsr.
- reqN_valid  in  1  request valid, N = 0, 1.
- reqN_ready  out  1  request accepted this cycle.
- reqN_op  in  1  0 = add, 1 = sub.
- reqN_rm  in  RM_W  instruction rounding mode.
- reqN_a, reqN_b  in  FP_SIZE  operands.
- reqN_tag  in  TAG_W  tag returned with the result.
- add_rm  out  RM_W  to adder, driven from stage 1.
- add_a, add_b  out  FP_SIZE  to adder, driven from stage 1.
- add_out  in  FP_SIZE  combinational adder result.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  FP_SIZE  result.
- rsp_tag  out  TAG_W  tag of the result.
- rsp_src  out  1  requester index of the result.
- rsp_count  out  16  completed responses, wraps modulo 2^16.

## Operation

- **Stage S1** holds the granted request's registers: s1_valid, rm, a, b, tag, src, special, special_val. add_a, add_b and add_rm are driven directly from S1.
- **Stage S2** holds the result registers: s2_valid, data, tag, src. All rsp_* outputs come from S2.
- **Advance condition.** s2_free = !s2_valid | rsp_ready. can_accept = !s1_valid | s2_free.
- **Grant.**
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - reqN_ready = can_accept & grantN.
  - last_grant is updated to the winner on every accepted handshake.
  - reqN_ready may depend on the other requester's valid. The two readies are never both high.
- **Operand transform at accept.**
  - For sub, b is replaced by {~b[FP_SIZE-1], b[FP_SIZE-2:0]}.
  - rm = (reqN_rm == 3'b111) ? frm : reqN_rm. frm is sampled in the accept cycle.
- **Special detection at accept**, evaluated on the transformed operands. Exp = bits [30:23], mantissa = bits [22:0].
  - Either operand is NaN (exp all ones, mantissa nonzero): special = 1, value 0x7FC00000.
  - Both operands are infinite (exp all ones, mantissa zero) with differing signs: special = 1, value 0x7FC00000.
  - Exactly one operand is infinite, or both are infinite with the same sign: special = 1, value = that infinity.
  - Otherwise special = 0.
- **S1 → S2 transfer.** When s1_valid & s2_free, S2 captures data = special ? special_val : add_out, together with tag and src.
  - s1_valid is cleared unless a new request is accepted in the same cycle.
  - Accept and transfer in the same cycle are legal; S1 is overwritten with the new request.
- **Response.** When rsp_valid & rsp_ready, rsp_count increments. s2_valid is cleared unless S1 transfers in the same cycle.
- **Ordering.** Results leave in acceptance order. There is no reordering.

## Timing

- **Reset values.**
  - s1_valid = 0, s2_valid = 0, so rsp_valid = 0.
  - rsp_data = 0, rsp_tag = 0, rsp_src = 0, rsp_count = 0.
  - add_a = 0, add_b = 0, add_rm = 0.
  - last_grant = 1, so req0 wins the first tie.
- **Latency.** A handshake in cycle t gives rsp_valid = 1 in cycle t+2 when the pipeline is unstalled.
- **Throughput.** One operation per cycle while rsp_ready stays high.
- **Stall.**
  - With rsp_ready low and both stages full, both reqN_ready are 0.
  - rsp_* outputs hold stable while rsp_valid & !rsp_ready.
  - S1 outputs hold while S1 is stalled.
- **Bubbles.** If no request is valid, S1 empties. S2 drains when rsp_ready is high.
- **Reset mid-operation.** Any in-flight request in S1 or S2 is discarded with no response. All registers return to their reset values in the cycle after reset is sampled high. reqN_ready = 0 while reset is high.
- **rsp_count** wraps from 0xFFFF to 0x0000.

## Test plan

- **Add.** req0 add, A = 0x3FA00000, B = 0x3FB00000, rm = 0, handshake at cycle t → rsp_valid at t+2, rsp_data = 0x40280000, rsp_tag echoed, rsp_src = 0, rsp_count = 1 after the handshake.
- **Sub.** req1 sub, A = 0x3FA00000, B = 0x3FC00000 → add_b = 0xBFC00000, rsp_data = 0xBE800000, rsp_src = 1. With reqN_rm = 7 and frm = 3, add_rm = 3.
- **Tie arbitration.** Both requesters valid continuously for 6 cycles after reset → grants alternate 0,1,0,1,0,1. rsp_src follows the same order with two-cycle latency. Both readies are never high together.
- **Backpressure.** Stream on req0 with rsp_ready held low for 4 cycles → after 2 accepts, req0_ready = 0. rsp_data/rsp_tag stay stable. On release, the remaining results drain in order with no loss or duplication.
- **Specials.**
  - A = 0x7FC00001 plus anything → 0x7FC00000.
  - 0x7F800000 sub 0x7F800000 → 0x7FC00000.
  - 0xFF800000 add 0x3F800000 → 0xFF800000.
  - In all three cases the add_out value is ignored.
- **Mid-operation reset.** Reset for 1 cycle with S1 and S2 full → rsp_valid = 0 and rsp_count = 0 next cycle. The first tie after reset is granted to req0.
